seven_seg_scan_driver: RTL and testbench

//  Time-multiplexed 7-segment display driver downstream of the wall-clock time counters.

---
 rtl/clock_display_pkg.sv | 41 ++++
 rtl/bcd_to_7seg.sv | 35 +++
 rtl/seven_seg_scan_driver.sv | 187 ++++++++++++++++++
 tb/tb_seven_seg_scan_driver.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_display_pkg.sv
// ---------------------------------------------------------------------------
// clock_display_pkg
//   Shared definitions for the wall-clock display blocks.
//   - SEG_* : active-low cathode codes for decimal digits 0..9, bit 7 (dp) = 1.
//   - SEG_BLANK / ANODE_OFF : all-off patterns for cathode and anode buses.
//   - display_snapshot_t : one coherent frame of display inputs.
//   - idx_width() : width of a digit index for a given digit count.
// ---------------------------------------------------------------------------
package clock_display_pkg;

  // Cathode encodings, active-low: [0]=a .. [6]=g, [7]=dp.
  localparam logic [7:0] SEG_0 = 8'hC0;
  localparam logic [7:0] SEG_1 = 8'hF9;
  localparam logic [7:0] SEG_2 = 8'hA4;
  localparam logic [7:0] SEG_3 = 8'hB0;
  localparam logic [7:0] SEG_4 = 8'h99;
  localparam logic [7:0] SEG_5 = 8'h92;
  localparam logic [7:0] SEG_6 = 8'h82;
  localparam logic [7:0] SEG_7 = 8'hF8;
  localparam logic [7:0] SEG_8 = 8'h80;
  localparam logic [7:0] SEG_9 = 8'h90;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] ANODE_OFF = 8'hFF;

  // The anode bus is 8 bits wide, so at most 8 digit positions exist.
  localparam int MAX_DIGITS = 8;

  // Inputs captured together at the start of each scan frame.
  typedef struct packed {
    logic [15:0] digits;  // four BCD nibbles, nibble i = digit i
    logic [3:0]  dp;      // decimal point per digit, 1 = lit
    logic [7:0]  pwm;     // brightness duty
  } display_snapshot_t;

  // Width of a digit index; a single-digit display still needs one bit.
  function automatic int idx_width(input int num_digits);
    return (num_digits <= 1) ? 1 : $clog2(num_digits);
  endfunction

endpackage

// File: rtl/bcd_to_7seg.sv
// ---------------------------------------------------------------------------
// bcd_to_7seg
//   Combinational BCD nibble to 7-segment decoder, active-low segments.
//   Non-decimal codes (10..15) turn every segment off.
// Ports
//   bcd_in     in  4  BCD digit
//   seg_n_out  out 7  segments, active-low: [0]=a .. [6]=g
// ---------------------------------------------------------------------------
module bcd_to_7seg
  import clock_display_pkg::*;
(
  input  logic [3:0] bcd_in,
  output logic [6:0] seg_n_out
);

  always_comb begin
    // NOTE: assigning a default before the case keeps every path driven,
    // so no latch is inferred when a code is not listed.
    seg_n_out = SEG_BLANK[6:0];
    case (bcd_in)
      4'd0:    seg_n_out = SEG_0[6:0];
      4'd1:    seg_n_out = SEG_1[6:0];
      4'd2:    seg_n_out = SEG_2[6:0];
      4'd3:    seg_n_out = SEG_3[6:0];
      4'd4:    seg_n_out = SEG_4[6:0];
      4'd5:    seg_n_out = SEG_5[6:0];
      4'd6:    seg_n_out = SEG_6[6:0];
      4'd7:    seg_n_out = SEG_7[6:0];
      4'd8:    seg_n_out = SEG_8[6:0];
      4'd9:    seg_n_out = SEG_9[6:0];
      default: seg_n_out = SEG_BLANK[6:0];
    endcase
  end

endmodule

// File: rtl/seven_seg_scan_driver.sv
// ---------------------------------------------------------------------------
// seven_seg_scan_driver
//   Time-multiplexed 7-segment driver for an HH:MM clock display. Each scan
//   frame starts by capturing digits, decimal points and brightness into a
//   shadow register so a frame never mixes old and new values. Every digit
//   slot begins with a short anode-off window that hides cathode changes,
//   and a free-running 8-bit PWM gates the anode for brightness.
// Parameters
//   NUM_DIGITS    active digit positions (1..8); other anodes stay off
//   REFRESH_DIV   clk cycles per digit slot (>= 2)
//   BLANK_CYCLES  anode-off cycles at the start of each slot (< REFRESH_DIV)
// Ports
//   CLK100MHZ       in   1   system clock
//   RESET_BTN       in   1   asynchronous active-low reset
//   digits_in       in   16  BCD digits, nibble i = digit i
//   dp_in           in   4   decimal points, 1 = lit
//   pwm_in          in   8   brightness duty, 0 = off, 255 = 255/256
//   SevenSegment    out  8   cathodes, active-low, [7] = dp
//   SegmentDrivers  out  8   anodes, active-low, bit i = digit i
//   frame_tick      out  1   one-cycle pulse when a new snapshot is captured
// ---------------------------------------------------------------------------
module seven_seg_scan_driver
  import clock_display_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic        CLK100MHZ,
  input  logic        RESET_BTN,
  input  logic [15:0] digits_in,
  input  logic [3:0]  dp_in,
  input  logic [7:0]  pwm_in,
  output logic [7:0]  SevenSegment,
  output logic [7:0]  SegmentDrivers,
  output logic        frame_tick
);

  localparam int PRESC_W = $clog2(REFRESH_DIV);
  localparam int IDX_W   = idx_width(NUM_DIGITS);

  localparam logic [PRESC_W-1:0] PRESC_LAST  = PRESC_W'(REFRESH_DIV - 1);
  localparam logic [PRESC_W-1:0] BLANK_LIMIT = PRESC_W'(BLANK_CYCLES);
  localparam logic [IDX_W-1:0]   IDX_LAST    = IDX_W'(NUM_DIGITS - 1);

  if (NUM_DIGITS < 1 || NUM_DIGITS > MAX_DIGITS) begin : g_bad_num_digits
    $error("NUM_DIGITS must be in 1..8");
  end
  if (REFRESH_DIV < 2) begin : g_bad_refresh_div
    $error("REFRESH_DIV must be at least 2");
  end
  if (BLANK_CYCLES >= REFRESH_DIV) begin : g_bad_blank_cycles
    $error("BLANK_CYCLES must be less than REFRESH_DIV");
  end

  // -------------------------------------------------------------------------
  // Reset synchronizer: assertion reaches every flop at once, release is
  // aligned to the clock so all counters leave reset on the same edge.
  // -------------------------------------------------------------------------
  logic [1:0] rst_sync_q, rst_sync_d;
  logic       rst_n;

  always_comb begin
    rst_sync_d = {rst_sync_q[0], 1'b1};
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the values from before the edge, independent of block order.
  always_ff @(posedge CLK100MHZ or negedge RESET_BTN) begin
    if (!RESET_BTN) begin
      rst_sync_q <= '0;
    end else begin
      rst_sync_q <= rst_sync_d;
    end
  end

  assign rst_n = rst_sync_q[1];

  // -------------------------------------------------------------------------
  // Scan state
  // -------------------------------------------------------------------------
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [7:0]         pwm_cnt_q, pwm_cnt_d;
  display_snapshot_t  snap_q, snap_d;
  logic               frame_tick_q, frame_tick_d;
  logic [7:0]         seg_q, seg_d;
  logic [7:0]         anode_q, anode_d;

  logic       slot_tick;
  logic       frame_wrap;
  logic [2:0] idx_ext;
  logic [3:0] nibble_sel;
  logic       dp_sel;
  logic [6:0] seg7;
  logic       pwm_on;
  logic       blank;
  logic       lit;

  assign slot_tick  = (presc_q == PRESC_LAST);
  assign frame_wrap = slot_tick && (idx_q == IDX_LAST);

  always_comb begin
    presc_d      = slot_tick ? '0 : presc_q + PRESC_W'(1);
    pwm_cnt_d    = pwm_cnt_q + 8'd1;
    idx_d        = idx_q;
    snap_d       = snap_q;
    frame_tick_d = 1'b0;

    if (slot_tick) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
    end

    // The capture coincides with idx returning to 0, so frame_tick and the
    // first slot of the new frame appear together.
    if (frame_wrap) begin
      snap_d.digits = digits_in;
      snap_d.dp     = dp_in;
      snap_d.pwm    = pwm_in;
      frame_tick_d  = 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // Pin decode from the current idx / pwm / blank state; registered below.
  // Positions 4..7 have no input data and show as blank.
  // -------------------------------------------------------------------------
  always_comb begin
    idx_ext    = 3'(idx_q);
    nibble_sel = 4'hF;
    dp_sel     = 1'b0;
    if (idx_ext < 3'd4) begin
      nibble_sel = snap_q.digits[{idx_ext[1:0], 2'b00} +: 4];
      dp_sel     = snap_q.dp[idx_ext[1:0]];
    end
  end

  bcd_to_7seg u_bcd_to_7seg (
    .bcd_in    (nibble_sel),
    .seg_n_out (seg7)
  );

  assign pwm_on = (pwm_cnt_q < snap_q.pwm);
  assign blank  = (presc_q < BLANK_LIMIT);
  assign lit    = pwm_on && !blank;

  always_comb begin
    anode_d = ANODE_OFF;
    seg_d   = SEG_BLANK;
    // Cathodes follow the anode: whenever no digit is driven they stay at
    // all-off so nothing glows during blanking or the PWM off phase.
    if (lit) begin
      anode_d[idx_ext] = 1'b0;
      seg_d            = {~dp_sel, seg7};
    end
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  always_ff @(posedge CLK100MHZ or negedge rst_n) begin
    if (!rst_n) begin
      presc_q      <= '0;
      idx_q        <= '0;
      pwm_cnt_q    <= '0;
      // NOTE: the snapshot is reset as well: a zero pwm shadow is what keeps
      // the display dark until the first frame has been captured.
      snap_q       <= '0;
      frame_tick_q <= 1'b0;
      seg_q        <= SEG_BLANK;
      anode_q      <= ANODE_OFF;
    end else begin
      presc_q      <= presc_d;
      idx_q        <= idx_d;
      pwm_cnt_q    <= pwm_cnt_d;
      snap_q       <= snap_d;
      frame_tick_q <= frame_tick_d;
      seg_q        <= seg_d;
      anode_q      <= anode_d;
    end
  end

  assign SevenSegment   = seg_q;
  assign SegmentDrivers = anode_q;
  assign frame_tick     = frame_tick_q;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// ---------------------------------------------------------------------------
// tb_seven_seg_scan_driver
//   Directed bench for seven_seg_scan_driver. Three builds share clock and
//   reset: the main one (REFRESH_DIV=8, BLANK_CYCLES=2, NUM_DIGITS=4), a
//   REFRESH_DIV=1024 build for the PWM duty measurement, and a NUM_DIGITS=2
//   build. The reset synchronizer holds the scan logic for two edges after
//   RESET_BTN rises; cnt counts the edges the scan logic has seen since then,
//   and the pins after count c show the state after count c-1.
// ---------------------------------------------------------------------------
module tb_seven_seg_scan_driver;

  localparam int RD       = 8;
  localparam int BLK      = 2;
  localparam int ND       = 4;
  localparam int FRAME    = RD * ND;
  localparam int RD_PWM   = 1024;
  localparam int RST_SYNC = 2;

  // Expected cathodes per digit slot, packed {digit3, digit2, digit1, digit0}.
  localparam logic [31:0] T1234 = 32'hF9A4_B099;
  localparam logic [31:0] T5678 = 32'h9282_F880;
  localparam logic [31:0] T00A0 = 32'hC040_FFC0;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] digits;
  logic [3:0]  dp;
  logic [7:0]  pwm;
  logic [7:0]  pwm_b;

  logic [7:0] seg,   an;   logic ft;
  logic [7:0] seg_p, an_p; logic ft_p;
  logic [7:0] seg_2, an_2; logic ft_2;

  int cyc;
  int cnt;
  int tests;
  int fails;

  always #5 clk = ~clk;

  seven_seg_scan_driver #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .BLANK_CYCLES(BLK)) dut (
    .CLK100MHZ(clk), .RESET_BTN(rst_n), .digits_in(digits), .dp_in(dp), .pwm_in(pwm),
    .SevenSegment(seg), .SegmentDrivers(an), .frame_tick(ft)
  );

  seven_seg_scan_driver #(.NUM_DIGITS(ND), .REFRESH_DIV(RD_PWM), .BLANK_CYCLES(BLK)) dut_pwm (
    .CLK100MHZ(clk), .RESET_BTN(rst_n), .digits_in(digits), .dp_in(dp), .pwm_in(pwm_b),
    .SevenSegment(seg_p), .SegmentDrivers(an_p), .frame_tick(ft_p)
  );

  seven_seg_scan_driver #(.NUM_DIGITS(2), .REFRESH_DIV(RD), .BLANK_CYCLES(BLK)) dut_n2 (
    .CLK100MHZ(clk), .RESET_BTN(rst_n), .digits_in(digits), .dp_in(dp), .pwm_in(pwm),
    .SevenSegment(seg_2), .SegmentDrivers(an_2), .frame_tick(ft_2)
  );

  // Expected {anode, cathode} for scan state s, given the cathode table and
  // duty captured for that frame.
  function automatic logic [15:0] model_pins(input int s, input logic [31:0] tab,
                                             input int duty, input int rd, input int nd);
    logic [7:0] an_m;
    int presc;
    int k;
    model_pins = 16'hFFFF;
    if (s >= 0) begin
      presc = s % rd;
      k     = (s / rd) % nd;
      if (presc >= BLK && (s % 256) < duty) begin
        an_m       = 8'hFF;
        an_m[k]    = 1'b0;
        model_pins = {an_m, tab[k*8 +: 8]};
      end
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    cnt = cyc - RST_SYNC;
  endtask

  task automatic release_reset();
    rst_n = 1'b1;
    cyc   = 0;
    cnt   = -RST_SYNC;
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    digits = 16'h1234;
    dp     = 4'b0000;
    pwm    = 8'd255;
    pwm_b  = 8'h40;
    repeat (3) tick();
    tests++; if (seg !== 8'hFF) begin fails++; $display("FAIL reset_seg got=%h exp=ff", seg); end
    tests++; if (an !== 8'hFF) begin fails++; $display("FAIL reset_anode got=%h exp=ff", an); end
    tests++; if (ft !== 1'b0) begin fails++; $display("FAIL reset_frame_tick got=%b exp=0", ft); end
    tests++; if (an_2 !== 8'hFF) begin fails++; $display("FAIL reset_anode_n2 got=%h exp=ff", an_2); end
    release_reset();
  endtask

  // Display stays dark until the first capture; frame_tick fires at count 32.
  task automatic test_power_up_dark();
    logic exp_ft;
    while (cnt < FRAME) begin
      tick();
      exp_ft = (cnt == FRAME);
      tests++;
      if ({an, seg} !== 16'hFFFF) begin
        fails++; $display("FAIL power_up_dark cnt=%0d pins=%h exp=ffff", cnt, {an, seg});
      end
      tests++;
      if (ft !== exp_ft) begin
        fails++; $display("FAIL power_up_frame_tick cnt=%0d got=%b exp=%b", cnt, ft, exp_ft);
      end
    end
  endtask

  // 1234 at full duty: FE/99, FD/B0, FB/A4, F7/F9 with a 2-cycle blank.
  task automatic test_scan_order();
    logic [15:0] exp_pins;
    logic        exp_ft;
    while (cnt < 2 * FRAME) begin
      tick();
      exp_pins = model_pins(cnt - 1, T1234, 255, RD, ND);
      exp_ft   = (cnt % FRAME == 0);
      tests++;
      if ({an, seg} !== exp_pins) begin
        fails++; $display("FAIL scan_order cnt=%0d pins=%h exp=%h", cnt, {an, seg}, exp_pins);
      end
      tests++;
      if (ft !== exp_ft) begin
        fails++; $display("FAIL scan_frame_tick cnt=%0d got=%b exp=%b", cnt, ft, exp_ft);
      end
    end
  endtask

  // Inputs changed two clocks into a frame only show from the next frame.
  task automatic test_snapshot();
    logic [15:0] exp_pins;
    logic        exp_ft;
    while (cnt < 4 * FRAME) begin
      tick();
      if (cnt == 2 * FRAME + 2) digits = 16'h5678;
      exp_pins = model_pins(cnt - 1, (cnt - 1 < 3 * FRAME) ? T1234 : T5678, 255, RD, ND);
      exp_ft   = (cnt % FRAME == 0);
      tests++;
      if ({an, seg} !== exp_pins) begin
        fails++; $display("FAIL snapshot cnt=%0d pins=%h exp=%h", cnt, {an, seg}, exp_pins);
      end
      tests++;
      if (ft !== exp_ft) begin
        fails++; $display("FAIL snapshot_frame_tick cnt=%0d got=%b exp=%b", cnt, ft, exp_ft);
      end
    end
  endtask

  // pwm_in=0 captured at count 160 darkens the whole following frame.
  task automatic test_pwm_zero();
    logic [15:0] exp_pins;
    pwm = 8'd0;
    while (cnt < 6 * FRAME) begin
      tick();
      exp_pins = model_pins(cnt - 1, T5678, (cnt - 1 < 5 * FRAME) ? 255 : 0, RD, ND);
      tests++;
      if ({an, seg} !== exp_pins) begin
        fails++; $display("FAIL pwm_zero cnt=%0d pins=%h exp=%h", cnt, {an, seg}, exp_pins);
      end
    end
  endtask

  // Non-decimal nibble blanks its cathodes; dp on digit 2 gives 40. The last
  // cycle of the frame lands on pwm_cnt=255, where full duty is still off.
  task automatic test_digit_decode();
    logic [15:0] exp_pins;
    digits = 16'h00A0;
    dp     = 4'b0100;
    pwm    = 8'd255;
    while (cnt < 8 * FRAME) begin
      tick();
      exp_pins = model_pins(cnt - 1, T00A0, (cnt - 1 < 7 * FRAME) ? 0 : 255, RD, ND);
      tests++;
      if ({an, seg} !== exp_pins) begin
        fails++; $display("FAIL digit_decode cnt=%0d pins=%h exp=%h", cnt, {an, seg}, exp_pins);
      end
    end
  endtask

  task automatic test_num_digits2();
    logic [15:0] exp_pins;
    logic        exp_ft;
    while (cnt < 9 * FRAME) begin
      tick();
      exp_pins = model_pins(cnt - 1, T00A0, 255, RD, 2);
      exp_ft   = (cnt % (2 * RD) == 0);
      tests++;
      if (an_2[7:2] !== 6'h3F) begin
        fails++; $display("FAIL n2_unused_anodes cnt=%0d got=%h exp=3f", cnt, an_2[7:2]);
      end
      tests++;
      if ({an_2, seg_2} !== exp_pins) begin
        fails++; $display("FAIL n2_scan cnt=%0d pins=%h exp=%h", cnt, {an_2, seg_2}, exp_pins);
      end
      tests++;
      if (ft_2 !== exp_ft) begin
        fails++; $display("FAIL n2_frame_tick cnt=%0d got=%b exp=%b", cnt, ft_2, exp_ft);
      end
    end
  endtask

  // Duty 0x40 captured at count 4096; measure 256 cycles well outside blank.
  task automatic test_pwm_duty();
    logic [15:0] exp_pins;
    int lit_count = 0;
    while (cnt < 4 * RD_PWM + 256) tick();
    repeat (256) begin
      tick();
      exp_pins = model_pins(cnt - 1, T00A0, 64, RD_PWM, ND);
      if (an_p !== 8'hFF) lit_count++;
      tests++;
      if ({an_p, seg_p} !== exp_pins) begin
        fails++; $display("FAIL pwm_duty_pins cnt=%0d pins=%h exp=%h", cnt, {an_p, seg_p}, exp_pins);
      end
    end
    tests++;
    if (lit_count !== 64) begin
      fails++; $display("FAIL pwm_duty_count got=%0d exp=64", lit_count);
    end
  endtask

  // Assert reset between edges while a digit is lit: pins go dark at once.
  task automatic test_async_reset();
    int waited = 0;
    while (an === 8'hFF && waited < 16) begin
      tick();
      waited++;
    end
    tests++;
    if (an === 8'hFF) begin
      fails++; $display("FAIL async_reset_lit_before got=%h exp=a lit digit", an);
    end
    #3;
    rst_n = 1'b0;
    #1;
    tests++; if (an !== 8'hFF) begin fails++; $display("FAIL async_reset_anode got=%h exp=ff", an); end
    tests++; if (seg !== 8'hFF) begin fails++; $display("FAIL async_reset_seg got=%h exp=ff", seg); end
    tests++; if (ft !== 1'b0) begin fails++; $display("FAIL async_reset_frame_tick got=%b exp=0", ft); end
    tests++; if (an_p !== 8'hFF) begin fails++; $display("FAIL async_reset_anode_pwm got=%h exp=ff", an_p); end
    repeat (3) tick();
    tests++;
    if ({an, seg} !== 16'hFFFF) begin
      fails++; $display("FAIL async_reset_held pins=%h exp=ffff", {an, seg});
    end
    release_reset();
  endtask

  initial begin
    tests = 0;
    fails = 0;
    cyc   = 0;
    cnt   = 0;
    test_reset();
    test_power_up_dark();
    test_scan_order();
    test_snapshot();
    test_pwm_zero();
    test_digit_decode();
    test_num_digits2();
    test_pwm_duty();
    test_async_reset();
    test_power_up_dark();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
